rr_decoder_arbiter: RTL and testbench

- Round-robin arbiter that shares one 2-to-4 decoded resource (four select lines) among four requesters.
- Registers the winning index as a 2-bit code plus a decode enable, and drives a one-hot select from them.
- Guarantees break-before-make between owners: at least one idle cycle with all selects low.
- Enforces a maximum hold time per grant.
- Sits between the requesting blocks and the shared decoder/mux datapath.

---
 rtl/rr_decoder_arbiter.sv | 75 +++++++
 tb/tb_rr_decoder_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rr_decoder_arbiter.sv
// rr_decoder_arbiter: four-requester round-robin arbiter with break-before-make gap, hold timeout and one-hot decoded select
module rr_decoder_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic       enable,
  output logic [1:0] sel,
  output logic [3:0] d,
  output logic       timeout,
  output logic [1:0] timeout_id
);
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  state_t state, state_nx;
  logic [1:0] last, last_nx, sel_nx, win, timeout_id_nx;
  logic enable_nx, timeout_nx, rel, hit;
  logic [CNT_W-1:0] cnt, cnt_nx;
  always_comb begin
    win = last;
    for (int k = 4; k >= 1; k--) if (req[last + 2'(k)]) win = last + 2'(k);
  end
  assign rel = done | ~req[sel];
  assign hit = (MAX_HOLD != 0) && (cnt == CNT_W'(MAX_HOLD - 1));
  assign d = {4{enable}} & (4'b0001 << sel);
  always_comb begin
    state_nx = state;
    last_nx = last;
    sel_nx = sel;
    enable_nx = enable;
    cnt_nx = cnt;
    timeout_nx = 1'b0;
    timeout_id_nx = timeout_id;
    case (state)
      IDLE: if (|req) begin
        state_nx = BUSY;
        sel_nx = win;
        enable_nx = 1'b1;
        cnt_nx = '0;
      end
      BUSY: begin
        cnt_nx = &cnt ? cnt : cnt + 1'b1;
        if (rel || hit) begin
          state_nx = GAP;
          enable_nx = 1'b0;
          last_nx = sel;
          timeout_nx = !rel;
          timeout_id_nx = rel ? timeout_id : sel;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last <= 2'd3;
      sel <= 2'd0;
      enable <= 1'b0;
      cnt <= '0;
      timeout <= 1'b0;
      timeout_id <= 2'd0;
    end else begin
      state <= state_nx;
      last <= last_nx;
      sel <= sel_nx;
      enable <= enable_nx;
      cnt <= cnt_nx;
      timeout <= timeout_nx;
      timeout_id <= timeout_id_nx;
    end
  end
endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// tb_rr_decoder_arbiter: randomized and directed checks of rr_decoder_arbiter against a behavioural model
module tb_rr_decoder_arbiter;
  localparam int MAXH = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [3:0] req = 4'b0;
  logic done = 1'b0;
  logic enable, timeout;
  logic [1:0] sel, timeout_id;
  logic [3:0] d;
  logic [9:0] got;
  int n_cmp = 0, n_bad = 0;
  int m_owner, m_sel, m_last, m_hold, m_toid;
  bit m_gap, m_to;
  always #5 clk = ~clk;
  rr_decoder_arbiter #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .done(done), .enable(enable),
    .sel(sel), .d(d), .timeout(timeout), .timeout_id(timeout_id)
  );
  assign got = {enable, sel, d, timeout, timeout_id};
  task automatic model_reset();
    m_owner = -1; m_sel = 0; m_last = 3; m_hold = 0; m_gap = 0; m_to = 0; m_toid = 0;
  endtask
  task automatic model_update(input logic [3:0] r, input logic dn);
    bit rel;
    m_to = 0;
    if (m_owner >= 0) begin
      rel = (dn === 1'b1) || (r[m_owner] === 1'b0);
      m_hold++;
      if (rel || m_hold == MAXH) begin
        if (!rel) begin m_to = 1; m_toid = m_owner; end
        m_last = m_owner; m_owner = -1; m_gap = 1;
      end
    end else if (m_gap) m_gap = 0;
    else if (r != 4'b0) begin
      for (int k = 1; k <= 4; k++) if (r[(m_last + k) % 4]) begin m_owner = (m_last + k) % 4; break; end
      m_sel = m_owner; m_hold = 0;
    end
  endtask
  function automatic logic [9:0] expv();
    logic [3:0] dv;
    logic en;
    en = (m_owner >= 0);
    dv = en ? 4'(1 << m_owner) : 4'b0;
    return {en, 2'(m_sel), dv, m_to, 2'(m_toid)};
  endfunction
  task automatic tick(input logic [3:0] r, input logic dn);
    req = r; done = dn;
    @(posedge clk);
    model_update(r, dn);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 1'b0; req = 4'b0; done = 1'b0;
    model_reset();
    #3 reset_n = 1'b1;
  endtask
  task automatic test_reset();
    #1 reset_n = 1'b0; req = 4'b1111; model_reset();
    #2 n_cmp++;
    if (got !== 10'b0) begin n_bad++; $display("FAIL reset_state got=%b exp=%b", got, 10'b0); end
    #1 reset_n = 1'b1;
    tick(4'b1111, 1'b0);
    n_cmp++;
    if ({enable, sel, d} !== 7'b1_00_0001) begin n_bad++; $display("FAIL first_grant got=%b exp=%b", {enable, sel, d}, 7'b1_00_0001); end
    n_cmp++;
    if (got !== expv()) begin n_bad++; $display("FAIL first_grant_model got=%b exp=%b", got, expv()); end
  endtask
  task automatic test_rotation();
    int order[$];
    int exp_o[5] = '{0, 1, 2, 3, 0};
    int low = 0;
    logic prev = 1'b0;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      tick(4'b1111, (m_owner >= 0 && m_hold == 2));
      n_cmp++;
      if (got !== expv()) begin n_bad++; $display("FAIL rotation cyc%0d got=%b exp=%b", i, got, expv()); end
      n_cmp++;
      if ($countones(d) > 1) begin n_bad++; $display("FAIL rotation_onehot cyc%0d d=%b exp=at most one bit", i, d); end
      if (enable && !prev) begin
        order.push_back(int'(sel));
        if (order.size() > 1) begin
          n_cmp++;
          if (low != 2) begin n_bad++; $display("FAIL rotation_gap cyc%0d low=%0d exp=2", i, low); end
        end
        low = 0;
      end else if (!enable) low++;
      prev = enable;
    end
    for (int j = 0; j < 5; j++) begin
      n_cmp++;
      if (order.size() <= j) begin n_bad++; $display("FAIL rotation_order idx%0d got=none exp=%0d", j, exp_o[j]); end
      else if (order[j] != exp_o[j]) begin n_bad++; $display("FAIL rotation_order idx%0d got=%0d exp=%0d", j, order[j], exp_o[j]); end
    end
  endtask
  task automatic test_single();
    int grants = 0;
    logic prev = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick(4'b0100, (m_owner >= 0 && m_hold == 1));
      n_cmp++;
      if (got !== expv()) begin n_bad++; $display("FAIL single cyc%0d got=%b exp=%b", i, got, expv()); end
      if (enable && !prev) begin
        grants++;
        n_cmp++;
        if (sel !== 2'd2) begin n_bad++; $display("FAIL single_sel cyc%0d got=%0d exp=2", i, sel); end
      end
      prev = enable;
    end
    n_cmp++;
    if (grants < 2) begin n_bad++; $display("FAIL single_regrant got=%0d exp=at least 2", grants); end
  endtask
  task automatic test_timeout();
    int high = 0, pulses = 0, next_sel = -1;
    bit dropped = 0;
    do_reset();
    tick(4'b0010, 1'b0);
    if (enable && sel == 2'd1) high++;
    for (int i = 0; i < 10; i++) begin
      tick(4'b1010, 1'b0);
      n_cmp++;
      if (got !== expv()) begin n_bad++; $display("FAIL timeout cyc%0d got=%b exp=%b", i, got, expv()); end
      if (!dropped && enable && sel == 2'd1) high++;
      if (!enable) dropped = 1;
      if (dropped && enable && next_sel < 0) next_sel = int'(sel);
      if (timeout && pulses == 0) begin
        pulses++;
        n_cmp++;
        if (timeout_id !== 2'd1 || enable !== 1'b0) begin n_bad++; $display("FAIL timeout_pulse got id=%0d en=%b exp id=1 en=0", timeout_id, enable); end
      end
    end
    n_cmp++;
    if (high != MAXH) begin n_bad++; $display("FAIL timeout_hold got=%0d exp=%0d", high, MAXH); end
    n_cmp++;
    if (pulses != 1) begin n_bad++; $display("FAIL timeout_seen got=%0d exp=1", pulses); end
    n_cmp++;
    if (next_sel != 3) begin n_bad++; $display("FAIL timeout_next got=%0d exp=3", next_sel); end
  endtask
  task automatic test_done_at_limit();
    do_reset();
    tick(4'b0001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(4'bxxx1, 1'b0);
      n_cmp++;
      if (got !== expv()) begin n_bad++; $display("FAIL limit_xreq cyc%0d got=%b exp=%b", i, got, expv()); end
    end
    tick(4'b0001, 1'b1);
    n_cmp++;
    if (timeout !== 1'b0 || enable !== 1'b0) begin n_bad++; $display("FAIL limit_release got to=%b en=%b exp to=0 en=0", timeout, enable); end
    tick(4'b0001, 1'b0);
    n_cmp++;
    if (got !== expv()) begin n_bad++; $display("FAIL limit_gap got=%b exp=%b", got, expv()); end
  endtask
  task automatic test_async_reset();
    do_reset();
    tick(4'b1111, 1'b0);
    tick(4'b1111, 1'b0);
    #3 reset_n = 1'b0;
    #1 n_cmp++;
    if ({enable, d, timeout} !== 6'b0) begin n_bad++; $display("FAIL async_reset got=%b exp=%b", {enable, d, timeout}, 6'b0); end
    model_reset();
    #2 reset_n = 1'b1;
    tick(4'b1010, 1'b0);
    n_cmp++;
    if ({enable, sel, d} !== 7'b1_01_0010) begin n_bad++; $display("FAIL async_regrant got=%b exp=%b", {enable, sel, d}, 7'b1_01_0010); end
    n_cmp++;
    if (got !== expv()) begin n_bad++; $display("FAIL async_model got=%b exp=%b", got, expv()); end
  endtask
  task automatic test_random();
    logic [3:0] r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = 4'($urandom);
      if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
      tick(r, ($urandom_range(0, 5) == 0));
      n_cmp++;
      if (got !== expv()) begin n_bad++; $display("FAIL random cyc%0d got=%b exp=%b", i, got, expv()); end
    end
  endtask
  initial begin
    test_reset();
    test_rotation();
    test_single();
    test_timeout();
    test_done_at_limit();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
